// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues single-outstanding imem word reads, buffers {pc, instr} in a DEPTH-entry FIFO for decode.
// Latency: request issues combinationally from instruction_ptr; data visible on instr one cycle after imem_rvalid.
// Backpressure: no request without FIFO space; pc_stall holds the PC until a request is granted. Optional FETCH_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  instruction_ptr,
  input  logic                   flush,
  output logic                   pc_stall,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  input  logic                   instr_ready,
  output logic                   fetch_fault
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // WAIT: a granted request is in flight. DRAIN: in-flight data is stale after a flush.
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          count;
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];

  logic                   space, misalign, push, pop, pc_adv;
  logic [INSTR_WIDTH-1:0] push_instr;
  logic [ADDR_WIDTH-1:0]  push_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic                   push_fault;
  logic                   fault_mem [DEPTH];
`endif

  assign space     = (count < CW'(DEPTH));
  assign imem_addr = instruction_ptr;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign  = (instruction_ptr[1:0] != 2'b00);
`else
  assign misalign  = 1'b0;
`endif

  // Next state, request issue and FIFO push selection; nothing is issued while in reset.
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    push       = 1'b0;
    pc_adv     = 1'b0;
    push_instr = imem_rdata;
    push_pc    = req_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
    push_fault = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rst && space && !flush) begin
          if (misalign) begin
            // Misaligned PC: skip memory, enqueue a fault entry and let the PC move on.
            push       = 1'b1;
            pc_adv     = 1'b1;
            push_pc    = instruction_ptr;
            push_instr = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            push_fault = 1'b1;
`endif
          end else begin
            imem_req = 1'b1;
            pc_adv   = imem_gnt;
            if (imem_gnt) state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          // A flush coinciding with the response simply drops it.
          state_nxt = IDLE;
          push      = !flush;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pc_stall    = !pc_adv;
  assign instr_valid = rst && (count != '0);
  assign pop         = instr_valid && instr_ready && !flush;
  assign instr       = instr_valid ? instr_mem[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]    : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault = instr_valid && fault_mem[rd_ptr];
`else
  assign fetch_fault = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Remember the address of the granted request to tag its returning data.
  always_ff @(posedge clk) begin
    if (!rst)                      req_addr <= '0;
    else if (imem_req && imem_gnt) req_addr <= instruction_ptr;
  end

  // FIFO occupancy and pointers; flush empties the buffer outright.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage write; push is already suppressed under flush.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= push_instr;
      pc_mem[wr_ptr]    <= push_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_mem[wr_ptr] <= push_fault;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level fetch model.
// Memory responder answers each grant 1..4 cycles later; decode ready, flush and reset are randomized.
// Expected outputs come from a queue of fetched {pc, data} plus an in-flight flag.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, imem_gnt, imem_rvalid, instr_ready;
  logic [63:0] instruction_ptr;
  logic [31:0] imem_rdata;
  logic        pc_stall, imem_req, instr_valid, fetch_fault;
  logic [63:0] imem_addr, instr_pc;
  logic [31:0] instr;

  int total = 0;
  int bad   = 0;

  // model state
  ent_t        q[$];
  bit          outstanding, dropped;
  logic [63:0] out_addr, pc;
  // responder state
  bit          rsp_pending;
  int          rsp_wait;
  logic [63:0] rsp_addr;
  // stimulus knobs (percent)
  int p_rst, p_flush, p_gnt, p_ready, max_dly;

  instr_fetch_unit #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .instruction_ptr(instruction_ptr), .flush(flush),
    .pc_stall(pc_stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fdata(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_0013;
  endfunction

  task automatic step();
    bit exp_req, exp_vld, accept, pop, delivered;
    @(negedge clk);
    rst         = !($urandom_range(99) < p_rst);
    flush       = ($urandom_range(99) < p_flush);
    instr_ready = ($urandom_range(99) < p_ready);
    imem_gnt    = !rsp_pending && ($urandom_range(99) < p_gnt);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (rsp_pending) begin
      if (rsp_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = fdata(rsp_addr);
      end else begin
        rsp_wait--;
      end
    end
    instruction_ptr = pc;
    #1;
    exp_req = rst && !outstanding && (q.size() < DEPTH) && !flush;
    exp_vld = rst && (q.size() != 0);
    chk("imem_req", imem_req, exp_req);
    chk("pc_stall", pc_stall, !(exp_req && imem_gnt));
    if (exp_req) chk("imem_addr", imem_addr, pc);
    chk("instr_valid", instr_valid, exp_vld);
    if (exp_vld) begin
      chk("instr", instr, q[0].d);
      chk("instr_pc", instr_pc, q[0].pc);
    end else begin
      chk("instr_idle", instr, 0);
      chk("instr_pc_idle", instr_pc, 0);
    end
    chk("fetch_fault", fetch_fault, 0);
    accept    = exp_req && imem_gnt;
    pop       = exp_vld && instr_ready;
    delivered = imem_rvalid && outstanding;
    @(posedge clk);
    if (imem_rvalid) rsp_pending = 0;
    if (!rst) begin
      q.delete();
      outstanding = 0;
      dropped     = 0;
    end else begin
      if (flush) begin
        q.delete();
        if (outstanding && !delivered) dropped = 1;
      end else begin
        if (pop) void'(q.pop_front());
        if (delivered && !dropped) q.push_back('{pc: out_addr, d: fdata(out_addr)});
      end
      if (delivered) begin
        outstanding = 0;
        dropped     = 0;
      end
      if (accept) begin
        outstanding = 1;
        out_addr    = pc;
        rsp_pending = 1;
        rsp_wait    = $urandom_range(0, max_dly);
        rsp_addr    = pc;
        pc          = pc + 64'd4;
      end
      if (flush) pc = {32'h0, $urandom} & ~64'h3;
    end
  endtask

  task automatic run(input int n, input int r, input int f, input int g, input int rd, input int d);
    p_rst = r; p_flush = f; p_gnt = g; p_ready = rd; max_dly = d;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    pc = 64'h0; outstanding = 0; dropped = 0; out_addr = '0;
    rsp_pending = 0; rsp_wait = 0; rsp_addr = '0;
    rst = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    instr_ready = 1'b0; instruction_ptr = '0; imem_rdata = '0;
    run(3, 100, 0, 100, 100, 0);   // reset held
    run(20, 0, 0, 100, 100, 0);    // ideal memory, 1 instr / 2 cycles
    run(10, 0, 0, 100, 0, 0);      // decode stalled: FIFO fills, PC stalls
    run(10, 0, 0, 100, 100, 0);    // drain and resume
    pc = 64'h40;
    run(5, 0, 0, 0, 100, 0);       // grant withheld
    run(6, 0, 0, 100, 100, 2);
    run(20, 0, 30, 100, 50, 3);    // flush-heavy with slow memory
    run(3000, 2, 8, 60, 60, 3);    // mixed random
    run(2, 100, 0, 0, 0, 0);

    // misaligned PC
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; instr_ready = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    rsp_pending = 0;
    instruction_ptr = 64'h102;
    #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_req", imem_req, 0);
    chk("mis_stall", pc_stall, 0);
    @(posedge clk);
    #1;
    chk("mis_valid", instr_valid, 1);
    chk("mis_pc", instr_pc, 64'h102);
    chk("mis_instr", instr, 0);
    chk("mis_fault", fetch_fault, 1);
`else
    chk("mis_req", imem_req, 1);
    chk("mis_addr", imem_addr, 64'h102);
    chk("mis_fault", fetch_fault, 0);
    chk("mis_stall", pc_stall, 1);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of PROGRAM_COUNTER. Consumes instruction_ptr and issues word reads to the instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions, tagged with their PC, in a small FIFO feeding decode over valid/ready.
- Back-pressures the PC through pc_stall so the PC advances only when a fetch request is accepted.
- flush discards buffered and in-flight fetches on a taken branch.

Parameters:
- ADDR_WIDTH, 64, PC / memory address width.
- INSTR_WIDTH, 32, instruction word width.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset, sampled at posedge clk.
- instruction_ptr  in  ADDR_WIDTH  current PC from PROGRAM_COUNTER.
- flush  in  1  discard all buffered and outstanding fetches; same cycle PC is redirected.
- pc_stall  out  1  1 = PC must hold its value this cycle.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_WIDTH  fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  INSTR_WIDTH  read data.
- instr_valid  out  1  FIFO head valid.
- instr  out  INSTR_WIDTH  FIFO head instruction.
- instr_pc  out  ADDR_WIDTH  PC of FIFO head.
- instr_ready  in  1  decode consumes head when instr_valid & instr_ready.
- fetch_fault  out  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset: rst==0 at posedge clk forces state IDLE, count=0 and drop=0. While rst is low, outputs are imem_req=0, instr_valid=0, fetch_fault=0 and pc_stall=1. instr and instr_pc are 0 whenever instr_valid=0.
- At most one request is outstanding.
- Space condition: count < DEPTH, counting only buffered entries.
- FSM states:
  - IDLE: imem_req = space & ~flush, with imem_addr = instruction_ptr (combinational, same cycle). On imem_req & imem_gnt, latch the request address and go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid, push {latched address, imem_rdata} into the FIFO and go to IDLE. A new request can issue the following cycle at the earliest.
  - DRAIN: imem_req=0. Wait for imem_rvalid, discard the data, go to IDLE.
- pc_stall = ~(imem_req & imem_gnt). The PC advances exactly once per accepted request.
- imem_rvalid arrives no earlier than the cycle after gnt. imem_rvalid in IDLE is ignored.
- FIFO:
  - Push in WAIT on rvalid. Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Read/write pointers wrap modulo DEPTH.
  - A pushed entry is visible on instr/instr_pc the cycle after imem_rvalid (registered).
  - Push is never attempted when full: a request is only issued with space, and pops only add space.
- Flush (priority over push and pop):
  - Clears count and pointers; instr_valid=0 next cycle.
  - In WAIT, the FSM goes to DRAIN.
  - In IDLE, no request is issued that cycle.
  - In DRAIN, it stays in DRAIN.
  - A flush in the same cycle as imem_rvalid in WAIT drops the data and goes to IDLE, not DRAIN.
- Steady-state throughput, single-cycle memory (gnt always 1, rvalid the next cycle): one instruction per 2 cycles.
- Reset in the middle of WAIT or DRAIN returns the FSM to IDLE. A stale imem_rvalid arriving afterward is ignored, because it lands in IDLE.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - In IDLE, if instruction_ptr[1:0] != 0 and space exists, no memory request is issued.
  - Instead, an entry {instruction_ptr, 0} is pushed directly with a fault bit set, and pc_stall=0 for that one cycle.
  - fetch_fault = head fault bit & instr_valid.
  - Fault entries obey flush and pop exactly like normal entries.
- Undefined:
  - Addresses are issued unchecked.
  - fetch_fault is tied 0 and no fault storage exists.

Test Plan:
1. rst=0 for 3 cycles, then 1; gnt=1, rvalid one cycle after gnt with rdata=32'h00000013; instr_ready=1 -> imem_addr sequence 0,4,8; instr_valid pulses every 2 cycles with instr_pc 0,4,8; pc_stall=1 during reset.
2. instr_ready=0, DEPTH=2 -> exactly 2 requests issued; then imem_req=0 and pc_stall=1 held. Raising instr_ready pops PC 0 then 4 in order, and requests resume.
3. gnt held 0 for 5 cycles with PC=0x40 -> imem_req=1, imem_addr=0x40 and pc_stall=1 throughout; first gnt gives a single PC advance.
4. Flush in WAIT with rvalid 3 cycles later carrying 32'hDEADBEEF -> DEADBEEF never appears on instr; the next request is issued at the new PC after rvalid.
5. Flush in the same cycle as a pop with count=2 -> count=0 and instr_valid=0 next cycle; no underflow.
6. With FETCH_MISALIGN_CHECK_EN and PC=0x102 -> no imem_req; instr_valid=1, instr_pc=0x102, fetch_fault=1. Without the macro -> imem_addr=0x102 and fetch_fault=0.
